// File: rtl/lfsr_draw_if.sv
// lfsr_draw_if: request/response bundle between a game-logic consumer and
// the lfsr_draw random-number generator.
//   req        consumer -> generator  draw request (accepted only when idle)
//   limit      consumer -> generator  range bound, 0 = full range
//   rnd_ready  consumer -> generator  consumer accepts rnd
//   rnd        generator -> consumer  drawn value
//   rnd_valid  generator -> consumer  rnd is valid, held until accepted
//   busy       generator -> consumer  a draw is in progress or pending
//   rejects    generator -> consumer  rejected attempts in the current draw
interface lfsr_draw_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req;
    logic [WIDTH-1:0] limit;
    logic             rnd_ready;
    logic [WIDTH-1:0] rnd;
    logic             rnd_valid;
    logic             busy;
    logic [7:0]       rejects;

    modport master (
        output req, limit, rnd_ready,
        input  rnd, rnd_valid, busy, rejects
    );

    modport slave (
        input  req, limit, rnd_ready,
        output rnd, rnd_valid, busy, rejects
    );
endinterface

// File: rtl/lfsr_draw.sv
// lfsr_draw: Fibonacci LFSR random-number generator. Each draw attempt is
// SHIFTS shifts long; with a nonzero limit the shifted state is masked to
// the smallest power-of-two range covering limit and attempts are repeated
// until the candidate falls below limit.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         shift enable; low freezes the LFSR and the shift counter
//   seed_load  load seed into the LFSR this cycle (wins over shifting)
//   seed       runtime seed; zero is replaced by all-ones
//   bus        request/response bundle (lfsr_draw_if slave side)
module lfsr_draw #(
    parameter int unsigned      WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter logic [WIDTH-1:0] SEED   = '1,
    parameter int unsigned      SHIFTS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    lfsr_draw_if.slave       bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, VALID} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       rej_q, rej_d;

    logic [WIDTH-1:0] s_shift;
    logic [WIDTH-1:0] seed_eff;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] mask_new;
    logic [WIDTH-1:0] lim_m1;
    logic             cand_ok;
    logic             last_shift;

    // An all-zero state can only arise from illegal taps; recover to all-ones.
    assign s_shift    = (s_q == '0) ? '1 : {s_q[WIDTH-2:0], ^(s_q & TAPS)};
    assign seed_eff   = (seed == '0) ? '1 : seed;
    assign cand       = s_shift & mask_q;
    assign cand_ok    = (lim_q == '0) || (cand < lim_q);
    assign last_shift = (cnt_q == 8'(SHIFTS - 1));

    // Mask = 2^k-1 for the smallest k with 2^k >= limit: smear the highest
    // set bit of (limit-1) downwards. limit==1 yields 0.
    always_comb begin
        lim_m1   = bus.limit - 1'b1;
        mask_new = lim_m1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            mask_new = mask_new | (lim_m1 >> i);
        end
        if (bus.limit == '0) begin
            mask_new = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        lim_d   = lim_q;
        mask_d  = mask_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        rej_d   = rej_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    lim_d   = bus.limit;
                    mask_d  = mask_new;
                    cnt_d   = '0;
                    rej_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    s_d = s_shift;
                    if (last_shift) begin
                        if (cand_ok) begin
                            rnd_d   = cand;
                            state_d = VALID;
                        end else begin
                            cnt_d = '0;
                            if (rej_q != 8'hFF) begin
                                rej_d = rej_q + 8'd1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            VALID: begin
                if (bus.rnd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Seed load overrides any shift decided above; mid-draw it restarts
        // the attempt from the new seed, discarding a same-cycle result.
        if (seed_load) begin
            s_d = seed_eff;
            if (state_q == SHIFT) begin
                cnt_d   = '0;
                rnd_d   = rnd_q;
                rej_d   = rej_q;
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= SEED;
            lim_q   <= '0;
            mask_q  <= '1;
            rnd_q   <= '0;
            cnt_q   <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            lim_q   <= lim_d;
            mask_q  <= mask_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
        end
    end

    assign bus.rnd       = rnd_q;
    assign bus.rnd_valid = (state_q == VALID);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rejects   = rej_q;

endmodule

// File: tb/tb_lfsr_draw.sv
module tb_lfsr_draw;

    typedef struct {
        logic [7:0] rnd;
        logic [7:0] rej;
        int         start;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       seed_load = 1'b0;
    logic [7:0] seed = '0;
    int         cyc = 0;
    int         checks = 0;
    int         passed = 0;
    exp_t       q[$];
    logic       prev_valid = 1'b0;

    lfsr_draw_if #(.WIDTH(8)) bus ();
    lfsr_draw_if #(.WIDTH(8)) bus2 ();

    lfsr_draw #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hFF), .SHIFTS(8)) dut (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed), .bus(bus)
    );

    lfsr_draw #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hFF), .SHIFTS(1)) dut1 (
        .clk(clk), .rst(rst), .en(1'b1), .seed_load(1'b0), .seed(8'h00), .bus(bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare each new result against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rnd_valid && !prev_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'(bus.rnd), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rnd", 32'(bus.rnd), 32'(e.rnd));
                check("rejects", 32'(bus.rejects), 32'(e.rej));
                check("latency", 32'(cyc - e.start), 32'(e.lat));
            end
        end
        prev_valid <= bus.rnd_valid && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issues a req in the current cycle (cycle 0); returns in cycle 1.
    task automatic start_draw(input logic [7:0] lim, input logic [7:0] r,
                              input logic [7:0] rj, input int lat, input bit push);
        exp_t e;
        e.rnd = r; e.rej = rj; e.start = cyc; e.lat = lat;
        if (push) q.push_back(e);
        bus.req = 1'b1;
        bus.limit = lim;
        tick();
        bus.req = 1'b0;
        bus.limit = 8'hA5;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.rnd_valid && n < 100) begin
            tick();
            n++;
        end
        if (!bus.rnd_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept();
        bus.rnd_ready = 1'b1;
        tick();
        bus.rnd_ready = 1'b0;
    endtask

    task automatic draw(input logic [7:0] lim, input logic [7:0] r,
                        input logic [7:0] rj, input int lat);
        start_draw(lim, r, rj, lat, 1'b1);
        wait_valid();
        accept();
    endtask

    initial begin
        int first_ff;
        bit saw_zero;
        bus.req = 1'b0; bus.limit = '0; bus.rnd_ready = 1'b0;
        bus2.req = 1'b0; bus2.limit = '0; bus2.rnd_ready = 1'b0;

        do_reset();
        check("reset_rnd", 32'(bus.rnd), 32'h0);
        check("reset_valid", 32'(bus.rnd_valid), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_rejects", 32'(bus.rejects), 32'h0);

        // Basic draw and rejection sampling
        draw(8'd0, 8'h0B, 8'd0, 9);
        do_reset();
        draw(8'd10, 8'h06, 8'd1, 17);

        // Stall mid-draw, then backpressure, then req during accept
        do_reset();
        start_draw(8'd0, 8'h0B, 8'd0, 12, 1'b1);
        tick(); tick();
        en = 1'b0;
        tick(); tick(); tick();
        en = 1'b1;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rnd", 32'(bus.rnd), 32'h0B);
            check("hold_valid", 32'(bus.rnd_valid), 32'h1);
        end
        bus.req = 1'b1;
        bus.limit = 8'd0;
        accept();
        bus.req = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'h0);
        tick();
        check("req_in_accept_ignored", 32'(bus.busy), 32'h0);

        // Seed of zero becomes all-ones
        do_reset();
        draw(8'd0, 8'h0B, 8'd0, 9);
        seed = 8'h00;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        draw(8'd0, 8'h0B, 8'd0, 9);

        // Seed load in cycle 4 of SHIFT restarts the draw; load in VALID keeps rnd
        do_reset();
        start_draw(8'd0, 8'hC6, 8'd0, 13, 1'b1);
        tick(); tick(); tick();
        seed = 8'h0B;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        wait_valid();
        seed = 8'h55;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("seed_in_valid_rnd", 32'(bus.rnd), 32'hC6);
        check("seed_in_valid_valid", 32'(bus.rnd_valid), 32'h1);
        accept();

        // limit=1 always yields zero
        do_reset();
        draw(8'd1, 8'h00, 8'd0, 9);

        // Reset mid-draw abandons the draw
        do_reset();
        start_draw(8'd0, 8'h00, 8'd0, 0, 1'b0);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_busy", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 12; i++) tick();
        check("midreset_no_valid", 32'(bus.rnd_valid), 32'h0);
        draw(8'd0, 8'h0B, 8'd0, 9);

        // Period of the maximal-length sequence with one shift per draw
        first_ff = 0;
        saw_zero = 1'b0;
        for (int d = 1; d <= 300 && first_ff == 0; d++) begin
            int n;
            bus2.req = 1'b1;
            tick();
            bus2.req = 1'b0;
            n = 0;
            while (!bus2.rnd_valid && n < 20) begin
                tick();
                n++;
            end
            if (!bus2.rnd_valid) begin
                check("period_timeout", 32'd0, 32'd1);
                break;
            end
            if (bus2.rnd == 8'h00) saw_zero = 1'b1;
            if (bus2.rnd == 8'hFF) first_ff = d;
            bus2.rnd_ready = 1'b1;
            tick();
            bus2.rnd_ready = 1'b0;
        end
        check("period_len", 32'(first_ff), 32'd255);
        check("period_nonzero", 32'(saw_zero), 32'd0);

        tick(); tick();
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_draw.md
# lfsr_draw

Parametrised Galois-free (Fibonacci) LFSR random-number generator with request/response handshake, runtime seed loading, and optional range limiting by rejection sampling. It serves game-logic blocks (spawn positions, enemy choice, timers) that need a fresh value on demand. Each draw is a whole number of shifts, so repeated draws are decorrelated, and every sequence is deterministic from reset.

## Interface
- WIDTH, 8: LFSR and output width; legal 3..32.
- TAPS, 8'hB8: feedback mask. Bit i set means state[i] is XORed into the feedback. The default gives feedback = s[7]^s[5]^s[4]^s[3].
- SEED, all-ones: state loaded on reset. Must be nonzero.
- SHIFTS, 8: shifts per draw attempt; legal 1..255.

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  shift enable; 0 freezes the LFSR and the shift counter
- seed_load  in  1  load `seed` into the LFSR this cycle
- seed  in  WIDTH  runtime seed; zero is replaced by all-ones
- req  in  1  draw request; accepted only in IDLE
- limit  in  WIDTH  range bound. 0 gives the full range; otherwise rnd < limit. Sampled when `req` is accepted.
- rnd  out  WIDTH  drawn value, registered
- rnd_valid  out  1  rnd is valid; held until accepted
- rnd_ready  in  1  consumer accepts rnd when high with rnd_valid
- busy  out  1  state != IDLE
- rejects  out  8  saturating count of rejected attempts in the current draw

## Operation
- The state machine has three states: IDLE, SHIFT, VALID.
- **IDLE**
  - When req=1, latch limit into lim_q and compute the mask.
  - Clear the shift count and rejects, then go to SHIFT.
  - The LFSR does not shift in IDLE.
- **SHIFT**
  - Each cycle with en=1: s <= {s[WIDTH-2:0], ^(s & TAPS)}, and the count increments.
  - With en=0, everything holds.
- **Final shift** (count == SHIFTS-1 with en=1)
  - cand = s_next & mask, where s_next is the shifted value.
  - If lim_q==0 or cand < lim_q: rnd <= cand, go to VALID.
  - Otherwise: count <= 0, rejects <= rejects+1 (saturating at 255), stay in SHIFT.
- **mask**
  - lim_q==0 gives all-ones.
  - Otherwise the mask is 2^k-1 with the smallest k such that 2^k >= lim_q. For lim_q=1 the mask is 0, so rnd is always 0.
  - This bounds the expected number of attempts to at most 2.
- **VALID**
  - rnd_valid=1; rnd and rejects hold.
  - When rnd_valid & rnd_ready: go to IDLE.
  - A req in that same cycle is ignored, so back-to-back draws need IDLE for one cycle.
- **seed_load** has priority over shifting in every state:
  - s <= (seed==0) ? all-ones : seed.
  - In SHIFT, the count resets to 0 and the draw restarts from the new seed; rejects are unchanged.
  - In VALID, rnd is unaffected.
- **Lockup guard:** if s is ever all-zero (illegal TAPS), the next shift loads all-ones.
- limit is ignored outside the req-accept cycle.

## Timing
- **Reset values:** s=SEED, state IDLE, rnd=0, rnd_valid=0, busy=0, rejects=0, count=0.
- **Reset mid-draw:** the draw is abandoned with no valid pulse and the LFSR returns to SEED.
- **Latency with en held high:** req sampled in cycle 0. Shifts occur at the ends of cycles 1..SHIFTS. rnd_valid rises in cycle SHIFTS+1.
  - Each rejection adds exactly SHIFTS cycles.
  - Each en=0 cycle adds one cycle.
- busy rises the cycle after req is accepted and falls the cycle after the handshake.
- rnd changes only on the transition into VALID.

## Test plan
- **Basic draw:** defaults, rst, en=1, limit=0, req pulse at cycle 0 -> rnd_valid in cycle 9, rnd=8'h0B, rejects=0.
  - Intermediate states: FF,FE,FC,F8,F0,E1,C2,85,0B.
- **Rejection:** after reset, limit=10, req.
  - Attempt 1: cand=0x0B, rejected.
  - Attempt 2: states 17,2F,5E,BC,78,F1,E3,C6.
  - Expected: rnd=8'h06, rejects=1, rnd_valid in cycle 17.
- **Stall and backpressure:**
  - en low for 3 cycles mid-draw -> rnd_valid in cycle 12 with rnd=0x0B.
  - Hold rnd_ready=0 for 5 cycles -> rnd and rnd_valid stable. Accept -> busy=0 the next cycle.
  - A req in the accept cycle is ignored.
- **Seed handling:**
  - seed_load with seed=0 -> s=FF.
  - seed_load with seed=8'h0B in cycle 4 of SHIFT -> draw restarts, rnd=8'hC6 eight cycles later.
  - seed_load in VALID -> rnd unchanged.
- **Edge limits and reset:**
  - limit=1 -> rnd=0, rejects=0.
  - rst asserted in cycle 5 of a draw -> no rnd_valid; the next draw yields 0x0B.
- **Period:** WIDTH=8, TAPS=8'hB8, repeated draws with SHIFTS=1 -> state returns to FF after exactly 255 draws and never reaches 0.
